// File: rtl/snake_pkg.sv
// Shared types, keycodes and direction helpers for the snake grid engine.
package snake_pkg;

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  typedef struct packed {
    logic valid;
    dir_t dir;
  } key_req_t;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_UP:   opposite = DIR_DOWN;
      DIR_DOWN: opposite = DIR_UP;
      DIR_LEFT: opposite = DIR_RIGHT;
      default:  opposite = DIR_LEFT;
    endcase
  endfunction

  function automatic key_req_t key_decode(input logic [7:0] code);
    key_req_t r;
    r.valid = 1'b1;
    case (code)
      KEY_W:   r.dir = DIR_UP;
      KEY_S:   r.dir = DIR_DOWN;
      KEY_A:   r.dir = DIR_LEFT;
      KEY_D:   r.dir = DIR_RIGHT;
      default: begin
        r.valid = 1'b0;
        r.dir   = DIR_UP;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/snake_grid_ctrl_if.sv
// Keyboard/colour-mapper side bundle of the snake engine.
interface snake_grid_ctrl_if #(
  parameter int unsigned GRID_W  = 40,
  parameter int unsigned GRID_H  = 30,
  parameter int unsigned MAX_LEN = 64
);
  localparam int unsigned XW = $clog2(GRID_W);
  localparam int unsigned YW = $clog2(GRID_H);
  localparam int unsigned IW = $clog2(MAX_LEN);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  logic [15:0]   keycode;
  logic          grow;
  logic [IW-1:0] seg_idx;
  logic [XW-1:0] seg_x;
  logic [YW-1:0] seg_y;
  logic          seg_valid;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [LW-1:0] length;
  logic          move_strobe;
  logic          running;
  logic          game_over;

  modport master (
    output keycode, grow, seg_idx,
    input  seg_x, seg_y, seg_valid, head_x, head_y, length,
           move_strobe, running, game_over
  );

  modport slave (
    input  keycode, grow, seg_idx,
    output seg_x, seg_y, seg_valid, head_x, head_y, length,
           move_strobe, running, game_over
  );
endinterface

// File: rtl/snake_key_decode.sv
// Two-byte HID keycode to direction request; the high byte wins when valid.
module snake_key_decode
  import snake_pkg::*;
(
  input  logic [15:0] keycode,
  output logic        req_valid,
  output dir_t        req_dir
);
  key_req_t lo;
  key_req_t hi;

  assign lo        = key_decode(keycode[7:0]);
  assign hi        = key_decode(keycode[15:8]);
  assign req_valid = lo.valid | hi.valid;
  assign req_dir   = hi.valid ? hi.dir : lo.dir;
endmodule

// File: rtl/snake_grid_ctrl.sv
// Grid snake engine: direction lock, move divider, circular segment buffer.
// SNAKE_WRAP_EN: grid edges wrap instead of ending the game.
module snake_grid_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W   = 40,
  parameter int unsigned GRID_H   = 30,
  parameter int unsigned MAX_LEN  = 64,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned STEP_DIV = 8
) (
  input logic Reset,
  input logic frame_clk,
  snake_grid_ctrl_if.slave bus
);
  localparam int unsigned XW = $clog2(GRID_W);
  localparam int unsigned YW = $clog2(GRID_H);
  localparam int unsigned IW = $clog2(MAX_LEN);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [XW-1:0] X_MAX    = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX    = YW'(GRID_H - 1);
  localparam logic [XW-1:0] X_HOME   = XW'(GRID_W / 2);
  localparam logic [YW-1:0] Y_HOME   = YW'(GRID_H / 2);
  localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);
  localparam logic [LW-1:0] LEN_INIT = LW'(INIT_LEN);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);
  localparam logic [IW-1:0] PTR_INIT = IW'(INIT_LEN - 1);

`ifdef SNAKE_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  state_t        state;
  dir_t          cur_dir;
  dir_t          dir_next;
  logic [DW-1:0] div;
  logic          grow_pend;
  logic [IW-1:0] head_ptr;
  logic [LW-1:0] len;
  logic [XW-1:0] hx;
  logic [YW-1:0] hy;
  logic          strobe;
  logic          run_q;
  logic          dead_q;
  logic [XW-1:0] buf_x [MAX_LEN];
  logic [YW-1:0] buf_y [MAX_LEN];

  logic          req_valid;
  dir_t          req_dir;
  logic          accept;
  logic          move_now;
  logic          grows;
  logic          at_edge;
  logic          wall;
  logic          hit;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic [LW-1:0] cmp_lim;
  logic [IW-1:0] rd_ptr;

  snake_key_decode u_key_decode (
    .keycode   (bus.keycode),
    .req_valid (req_valid),
    .req_dir   (req_dir)
  );

  assign accept   = req_valid && (req_dir != opposite(cur_dir)) && (state != S_DEAD);
  assign move_now = (state == S_RUN) && (div == DIV_LAST);
  assign grows    = grow_pend && (len < LEN_MAX);
  assign wall     = at_edge && !WRAP;

  // Candidate head; edge cells wrap to the opposite side (used only when wrapping).
  always_comb begin
    nx      = hx;
    ny      = hy;
    at_edge = 1'b0;
    case (dir_next)
      DIR_UP: begin
        at_edge = (hy == '0);
        ny      = at_edge ? Y_MAX : hy - YW'(1);
      end
      DIR_DOWN: begin
        at_edge = (hy == Y_MAX);
        ny      = at_edge ? '0 : hy + YW'(1);
      end
      DIR_LEFT: begin
        at_edge = (hx == '0);
        nx      = at_edge ? X_MAX : hx - XW'(1);
      end
      default: begin
        at_edge = (hx == X_MAX);
        nx      = at_edge ? '0 : hx + XW'(1);
      end
    endcase
  end

  // Body compare; the tail cell vacates this move unless the snake grows.
  always_comb begin
    hit     = 1'b0;
    cmp_lim = grows ? len : len - LW'(1);
    for (int unsigned k = 1; k < MAX_LEN; k++) begin
      if ((LW'(k) < cmp_lim) &&
          (buf_x[head_ptr - IW'(k)] == nx) &&
          (buf_y[head_ptr - IW'(k)] == ny))
        hit = 1'b1;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      cur_dir   <= DIR_RIGHT;
      dir_next  <= DIR_RIGHT;
      div       <= '0;
      grow_pend <= 1'b0;
      head_ptr  <= PTR_INIT;
      len       <= LEN_INIT;
      hx        <= X_HOME;
      hy        <= Y_HOME;
      strobe    <= 1'b0;
      run_q     <= 1'b0;
      dead_q    <= 1'b0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        buf_x[i] <= (i < INIT_LEN) ? XW'(GRID_W / 2 + i - (INIT_LEN - 1)) : '0;
        buf_y[i] <= (i < INIT_LEN) ? Y_HOME : '0;
      end
    end else begin
      strobe    <= 1'b0;
      grow_pend <= move_now ? bus.grow : (grow_pend | bus.grow);
      if (accept) dir_next <= req_dir;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= S_RUN;
            run_q <= 1'b1;
            div   <= '0;
          end
        end
        S_RUN: begin
          div <= move_now ? '0 : div + DW'(1);
          if (move_now) begin
            if (wall || hit) begin
              state  <= S_DEAD;
              run_q  <= 1'b0;
              dead_q <= 1'b1;
            end else begin
              head_ptr                  <= head_ptr + IW'(1);
              buf_x[head_ptr + IW'(1)]  <= nx;
              buf_y[head_ptr + IW'(1)]  <= ny;
              hx                        <= nx;
              hy                        <= ny;
              cur_dir                   <= dir_next;
              strobe                    <= 1'b1;
              if (grows) len <= len + LW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_ptr          = head_ptr - bus.seg_idx;
  assign bus.seg_x       = buf_x[rd_ptr];
  assign bus.seg_y       = buf_y[rd_ptr];
  assign bus.seg_valid   = LW'(bus.seg_idx) < len;
  assign bus.head_x      = hx;
  assign bus.head_y      = hy;
  assign bus.length      = len;
  assign bus.move_strobe = strobe;
  assign bus.running     = run_q;
  assign bus.game_over   = dead_q;
endmodule

// File: tb/tb_snake_grid_ctrl.sv
// Self-checking bench: list-based snake model, directed scenarios, random play.
module tb_snake_grid_ctrl;
  localparam int GRID_W   = 40;
  localparam int GRID_H   = 30;
  localparam int MAX_LEN  = 64;
  localparam int INIT_LEN = 3;
  localparam int STEP_DIV = 8;

  logic Reset;
  logic frame_clk;

  snake_grid_ctrl_if #(.GRID_W(GRID_W), .GRID_H(GRID_H), .MAX_LEN(MAX_LEN)) bus ();

  snake_grid_ctrl #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .MAX_LEN(MAX_LEN),
    .INIT_LEN(INIT_LEN), .STEP_DIV(STEP_DIV)
  ) dut (
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Model: mx/my[0] is the head, index k is k cells behind it. Dirs 0=U 1=D 2=L 3=R.
  int mx [MAX_LEN];
  int my [MAX_LEN];
  int m_len, m_state, m_cur, m_next, m_div, m_gp;
  int m_strobe;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int key_dir(input logic [7:0] k);
    case (k)
      8'h1A:   return 0;
      8'h16:   return 1;
      8'h04:   return 2;
      8'h07:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int opp(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 3 : 2;
  endfunction

  task automatic model_reset();
    m_len = INIT_LEN;
    for (int k = 0; k < MAX_LEN; k++) begin
      mx[k] = GRID_W / 2 - k;
      my[k] = GRID_H / 2;
    end
    m_state = 0; m_cur = 3; m_next = 3; m_div = 0; m_gp = 0; m_strobe = 0;
  endtask

  task automatic model_step();
    int hd, ld, rq, nx, ny, lim;
    bit acc, move, grows, out, hit;
    hd = key_dir(bus.keycode[15:8]);
    ld = key_dir(bus.keycode[7:0]);
    rq = (hd >= 0) ? hd : ld;
    acc = (rq >= 0) && (rq != opp(m_cur)) && (m_state != 2);
    move = (m_state == 1) && (m_div == STEP_DIV - 1);
    m_strobe = 0;
    if (m_state == 1) begin
      m_div = move ? 0 : m_div + 1;
      if (move) begin
        nx = mx[0] + ((m_next == 2) ? -1 : (m_next == 3) ? 1 : 0);
        ny = my[0] + ((m_next == 0) ? -1 : (m_next == 1) ? 1 : 0);
        out = (nx < 0) || (nx >= GRID_W) || (ny < 0) || (ny >= GRID_H);
`ifdef SNAKE_WRAP_EN
        nx = (nx + GRID_W) % GRID_W;
        ny = (ny + GRID_H) % GRID_H;
        out = 1'b0;
`endif
        grows = (m_gp != 0) && (m_len < MAX_LEN);
        lim = grows ? m_len : m_len - 1;
        hit = 1'b0;
        for (int k = 1; k < lim; k++)
          if (mx[k] == nx && my[k] == ny) hit = 1'b1;
        if (out || hit) m_state = 2;
        else begin
          for (int k = MAX_LEN - 1; k > 0; k--) begin
            mx[k] = mx[k-1];
            my[k] = my[k-1];
          end
          mx[0] = nx; my[0] = ny;
          if (grows) m_len++;
          m_cur = m_next;
          m_strobe = 1;
        end
      end
    end else if (m_state == 0 && acc) begin
      m_state = 1;
      m_div = 0;
    end
    m_gp = move ? int'(bus.grow) : (m_gp | int'(bus.grow));
    if (acc) m_next = rq;
  endtask

  always @(posedge frame_clk) begin
    if (Reset) model_reset();
    else model_step();
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge frame_clk) begin
    int idx;
    if (chk_en) begin
      chk("head_x", int'(bus.head_x), mx[0]);
      chk("head_y", int'(bus.head_y), my[0]);
      chk("length", int'(bus.length), m_len);
      chk("move_strobe", int'(bus.move_strobe), m_strobe);
      chk("running", int'(bus.running), int'(m_state == 1));
      chk("game_over", int'(bus.game_over), int'(m_state == 2));
      idx = int'(bus.seg_idx);
      chk("seg_valid", int'(bus.seg_valid), int'(idx < m_len));
      if (idx < m_len) begin
        chk("seg_x", int'(bus.seg_x), mx[idx]);
        chk("seg_y", int'(bus.seg_y), my[idx]);
      end
    end
  end

  task automatic tick();
    @(posedge frame_clk);
    #2;
  endtask

  task automatic do_reset(input int dly);
    #(dly);
    Reset = 1'b1;
    model_reset();
    @(posedge frame_clk);
    #2;
    Reset = 1'b0;
  endtask

  task automatic wait_move(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 4 * STEP_DIV && !seen; i++) begin
      tick();
      if (bus.move_strobe) seen = 1'b1;
    end
    chk({name, "_move_seen"}, int'(seen), 1);
  endtask

  task automatic wait_dead(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 4 * STEP_DIV && !seen; i++) begin
      tick();
      if (bus.game_over) seen = 1'b1;
    end
    chk({name, "_dead_seen"}, int'(seen), 1);
  endtask

  task automatic key_pulse(input logic [15:0] k);
    bus.keycode = k;
    tick();
    bus.keycode = 16'h0000;
  endtask

  function automatic logic [15:0] steer();
    if (m_state == 0) return 16'h0007;
    if (m_cur == 3 && mx[0] >= GRID_W - 2) return 16'h0016;
    if (m_cur == 2 && mx[0] <= 1) return 16'h0016;
    if (m_cur == 1) return (mx[0] >= GRID_W - 2) ? 16'h0004 : 16'h0007;
    return 16'h0000;
  endfunction

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 5))
      0: return 8'h1A;
      1: return 8'h16;
      2: return 8'h04;
      3: return 8'h07;
      4: return 8'(($urandom));
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    Reset = 1'b1;
    bus.keycode = 16'h0000;
    bus.grow = 1'b0;
    bus.seg_idx = '0;
    model_reset();
    chk_en = 1'b1;
    tick();
    Reset = 1'b0;

    // Idle: nothing moves without a key.
    repeat (100) tick();
    chk("idle_head_x", int'(bus.head_x), 20);
    chk("idle_head_y", int'(bus.head_y), 15);
    chk("idle_length", int'(bus.length), 3);
    chk("idle_running", int'(bus.running), 0);
    bus.seg_idx = 6'd1; #1;
    chk("idle_seg1_x", int'(bus.seg_x), 19);
    chk("idle_seg1_y", int'(bus.seg_y), 15);
    bus.seg_idx = 6'd2; #1;
    chk("idle_seg2_x", int'(bus.seg_x), 18);
    chk("idle_seg2_y", int'(bus.seg_y), 15);
    bus.seg_idx = 6'd3; #1;
    chk("idle_seg3_valid", int'(bus.seg_valid), 0);

    // Start RIGHT; first move STEP_DIV edges after entering RUN.
    key_pulse(16'h0007);
    chk("start_running", int'(bus.running), 1);
    repeat (STEP_DIV - 1) tick();
    chk("pre_move_head_x", int'(bus.head_x), 20);
    tick();
    chk("move1_head_x", int'(bus.head_x), 21);
    chk("move1_strobe", int'(bus.move_strobe), 1);

    // Reversal ignored, then high byte wins.
    key_pulse(16'h0004);
    wait_move("rev");
    chk("rev_head_x", int'(bus.head_x), 22);
    chk("rev_head_y", int'(bus.head_y), 15);
    key_pulse(16'h1A07);
    wait_move("hi");
    chk("hi_head_x", int'(bus.head_x), 22);
    chk("hi_head_y", int'(bus.head_y), 14);

    // Single grow pulse keeps the old tail.
    bus.grow = 1'b1; tick(); bus.grow = 1'b0;
    wait_move("grow");
    chk("grow_length", int'(bus.length), 4);
    bus.seg_idx = 6'd3; #1;
    chk("grow_tail_x", int'(bus.seg_x), 21);
    chk("grow_tail_y", int'(bus.seg_y), 15);
    bus.seg_idx = '0;

    // Serpentine with grow held: length saturates.
    do_reset(1);
    bus.grow = 1'b1;
    for (int c = 0; c < 900; c++) begin
      bus.keycode = steer();
      tick();
    end
    bus.grow = 1'b0;
    bus.keycode = 16'h0000;
    chk("sat_length", int'(bus.length), 64);
    chk("sat_alive", int'(bus.game_over), 0);

    // Edge of grid moving RIGHT.
    do_reset(2);
    key_pulse(16'h0007);
    for (int i = 0; i < 19; i++) wait_move("edge");
    chk("edge_head_x", int'(bus.head_x), 39);
`ifdef SNAKE_WRAP_EN
    wait_move("wrap");
    chk("wrap_head_x", int'(bus.head_x), 0);
    chk("wrap_head_y", int'(bus.head_y), 15);
`else
    wait_dead("wall");
    chk("wall_game_over", int'(bus.game_over), 1);
    chk("wall_head_x", int'(bus.head_x), 39);
`endif

    // Length 5 then DOWN, LEFT, UP bites the body.
    do_reset(1);
    key_pulse(16'h0007);
    wait_move("self0");
    bus.grow = 1'b1; tick(); bus.grow = 1'b0;
    wait_move("self1");
    bus.grow = 1'b1; tick(); bus.grow = 1'b0;
    wait_move("self2");
    chk("self_len5", int'(bus.length), 5);
    key_pulse(16'h0016); wait_move("self_down");
    key_pulse(16'h0004); wait_move("self_left");
    key_pulse(16'h001A); wait_dead("self_up");
    chk("self_game_over", int'(bus.game_over), 1);
    chk("self_length", int'(bus.length), 5);
    chk("self_head_x", int'(bus.head_x), 22);
    chk("self_head_y", int'(bus.head_y), 16);
    bus.keycode = 16'h0007;
    repeat (30) tick();
    bus.keycode = 16'h0000;
    chk("dead_holds", int'(bus.game_over), 1);
    do_reset(2);
    chk("recover_game_over", int'(bus.game_over), 0);
    chk("recover_running", int'(bus.running), 0);

    // Random play with occasional asynchronous resets.
    for (int ep = 0; ep < 20; ep++) begin
      int ncyc;
      do_reset(int'($urandom_range(1, 2)));
      ncyc = int'($urandom_range(500, 1500));
      for (int c = 0; c < ncyc; c++) begin
        if ($urandom_range(0, 3) == 0) bus.keycode = {rand_byte(), rand_byte()};
        else bus.keycode = 16'h0000;
        bus.grow = ($urandom_range(0, 15) == 0);
        bus.seg_idx = 6'($urandom_range(0, MAX_LEN - 1));
        tick();
        if ($urandom_range(0, 999) == 0) do_reset(int'($urandom_range(1, 2)));
      end
    end

    bus.keycode = 16'h0000;
    bus.grow = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
